window_buffer_3x3: RTL

WINDOW_BUFFER_3X3 -- requirements
Module: window_buffer_3x3

---
 rtl/window_buffer_3x3.sv | 105 ++++++++++
 1 files changed

// File: rtl/window_buffer_3x3.sv
// 3x3 sliding-window generator for a raster-order 8-bit grey image.
// Two line buffers hold the previous two rows; the window advances by one
// column on every accepted pixel. win_valid flags windows that lie fully
// inside the image, and frame_done pulses after the last pixel of a frame.
module window_buffer_3x3 #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] mat00,
  output logic [7:0] mat01,
  output logic [7:0] mat02,
  output logic [7:0] mat10,
  output logic [7:0] mat11,
  output logic [7:0] mat12,
  output logic [7:0] mat20,
  output logic [7:0] mat21,
  output logic [7:0] mat22,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int DATA_W = 8;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     cur_row;
  logic              last_col;
  logic              last_row;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  // Position of the pixel being accepted: sof forces (0,0) regardless of counters.
  always_comb begin
    cur_col  = col;
    cur_row  = row;
    if (sof) begin
      cur_col = '0;
      cur_row = '0;
    end
    last_col = (cur_col == CW'(IMG_WIDTH - 1));
    last_row = (cur_row == RW'(IMG_HEIGHT - 1));
    lb0_rd   = lb0[cur_col];
    lb1_rd   = lb1[cur_col];
  end

  // Raster position counters, advanced only by accepted pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers: read-before-write, so the window sees the older rows at this column.
  // Contents survive reset; stale data never reaches a flagged window.
  always_ff @(posedge clk) begin
    if (rst_n && pix_valid) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= pix_in;
    end
  end

  // Stage boundary: accepted pixel -> registered 3x3 window (one cycle latency).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mat00 <= '0; mat01 <= '0; mat02 <= '0;
      mat10 <= '0; mat11 <= '0; mat12 <= '0;
      mat20 <= '0; mat21 <= '0; mat22 <= '0;
    end else if (pix_valid) begin
      mat00 <= mat01; mat01 <= mat02; mat02 <= lb1_rd;
      mat10 <= mat11; mat11 <= mat12; mat12 <= lb0_rd;
      mat20 <= mat21; mat21 <= mat22; mat22 <= pix_in;
    end
  end

  // Window qualifier and end-of-frame pulse, aligned with the window registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_done <= pix_valid && last_col && last_row;
    end
  end

endmodule
